sync_timing_tracker: RTL and testbench

//  Parametrised successor to the sync-to-count block. Converts incoming HSync/VSync into
//  row/col counters aligned with the 1-cycle-delayed syncs, and adds active-area decode,

---
 rtl/sync_timing_tracker.sv | 143 ++++++++++++++
 tb/tb_sync_timing_tracker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_timing_tracker.sv
// Converts raw HSync/VSync into row/col counters aligned with the 1-clk delayed syncs, plus
// active-area decode, start strobes and a frame-length lock monitor. Optional stats: SYNC_TRACKER_STATS_EN.
module sync_timing_tracker #(
    parameter int TOTAL_COLS   = 800,
    parameter int TOTAL_ROWS   = 525,
    parameter int ACTIVE_COLS  = 640,
    parameter int ACTIVE_ROWS  = 480,
    parameter int COL_W        = 10,
    parameter int ROW_W        = 10,
    parameter bit SYNC_ACT_LOW = 1'b0,
    parameter int LOCK_FRAMES  = 3
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_HSync,
    input  logic             i_VSync,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic [COL_W-1:0] o_Col_Count,
    output logic [ROW_W-1:0] o_Row_Count,
    output logic             o_Active,
    output logic             o_Frame_Start,
    output logic             o_Line_Start,
    output logic             o_Locked,
    output logic             o_Lock_Err,
    output logic [15:0]      o_Frame_Count,
    output logic [7:0]       o_Err_Count,
    output logic [1:0]       o_State
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;

    state_t     state;
    logic [3:0] good_cnt;
    logic       vsync_edge;
    logic       col_last;
    logic       row_last;
    logic       frame_end;
    logic       frame_bad;

    assign vsync_edge = SYNC_ACT_LOW ? (~i_VSync & o_VSync) : (i_VSync & ~o_VSync);
    assign col_last   = (32'(o_Col_Count) == TOTAL_COLS - 1);
    assign row_last   = (32'(o_Row_Count) == TOTAL_ROWS - 1);
    assign frame_end  = col_last && row_last;
    // An edge away from FrameEnd, or FrameEnd with no edge, both mean a wrong-length frame.
    assign frame_bad  = vsync_edge ^ frame_end;

    // Decodes are gated by reset so every output reads 0 while reset is held.
    assign o_Active     = ~i_Rst && (32'(o_Col_Count) < ACTIVE_COLS) && (32'(o_Row_Count) < ACTIVE_ROWS);
    assign o_Line_Start = ~i_Rst && (o_Col_Count == '0);
    assign o_State      = state;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_HSync <= i_HSync;
            o_VSync <= i_VSync;
            if (vsync_edge) begin
                o_Col_Count   <= '0;
                o_Row_Count   <= '0;
                o_Frame_Start <= 1'b1;
            end else begin
                o_Frame_Start <= 1'b0;
                if (col_last) begin
                    o_Col_Count <= '0;
                    o_Row_Count <= row_last ? '0 : o_Row_Count + 1'b1;
                end else begin
                    o_Col_Count <= o_Col_Count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            good_cnt   <= '0;
            o_Locked   <= 1'b0;
            o_Lock_Err <= 1'b0;
        end else begin
            o_Lock_Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (vsync_edge) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (vsync_edge && frame_end) begin
                        good_cnt <= 4'(good_cnt + 4'd1);
                        if (32'(good_cnt) + 1 == LOCK_FRAMES) begin
                            state    <= LOCKED;
                            o_Locked <= 1'b1;
                        end
                    end else if (frame_bad) begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (frame_bad) begin
                        state      <= ACQ;
                        good_cnt   <= '0;
                        o_Locked   <= 1'b0;
                        o_Lock_Err <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    good_cnt <= '0;
                    o_Locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYNC_TRACKER_STATS_EN
    logic lock_loss;
    assign lock_loss = (state == LOCKED) && frame_bad;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Frame_Count <= '0;
            o_Err_Count   <= '0;
        end else begin
            if (vsync_edge)
                o_Frame_Count <= o_Frame_Count + 16'd1;
            // Counted together with the o_Lock_Err pulse; saturates instead of wrapping.
            if (lock_loss && o_Err_Count != 8'hFF)
                o_Err_Count <= o_Err_Count + 8'd1;
        end
    end
`else
    assign o_Frame_Count = '0;
    assign o_Err_Count   = '0;
`endif

endmodule

// File: tb/tb_sync_timing_tracker.sv
// Directed bench for sync_timing_tracker: 10x6 frame, 8x4 active, lock after 3 good frames,
// with a second instance using active-low VSync fed the inverted sync.
module tb_sync_timing_tracker;

    localparam int TC = 10;
    localparam int TR = 6;

    logic        clk;
    logic        rst;
    logic        hs;
    logic        vs;
    logic        vs2;

    logic        o_hs, o_vs, o_act, o_fs, o_ls, o_lock, o_err;
    logic [3:0]  o_col;
    logic [2:0]  o_row;
    logic [15:0] o_fcnt;
    logic [7:0]  o_ecnt;
    logic [1:0]  o_state;

    logic        o2_hs, o2_vs, o2_act, o2_fs, o2_ls, o2_lock, o2_err;
    logic [3:0]  o2_col;
    logic [2:0]  o2_row;
    logic [15:0] o2_fcnt;
    logic [7:0]  o2_ecnt;
    logic [1:0]  o2_state;

    int vectors;
    int miscompares;
    int err_seen;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    assign vs2 = ~vs;

    sync_timing_tracker #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(8), .ACTIVE_ROWS(4),
        .COL_W(4), .ROW_W(3), .SYNC_ACT_LOW(1'b0), .LOCK_FRAMES(3)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_HSync(hs), .i_VSync(vs),
        .o_HSync(o_hs), .o_VSync(o_vs), .o_Col_Count(o_col), .o_Row_Count(o_row),
        .o_Active(o_act), .o_Frame_Start(o_fs), .o_Line_Start(o_ls),
        .o_Locked(o_lock), .o_Lock_Err(o_err), .o_Frame_Count(o_fcnt),
        .o_Err_Count(o_ecnt), .o_State(o_state)
    );

    sync_timing_tracker #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(8), .ACTIVE_ROWS(4),
        .COL_W(4), .ROW_W(3), .SYNC_ACT_LOW(1'b1), .LOCK_FRAMES(3)
    ) dut_low (
        .i_Clk(clk), .i_Rst(rst), .i_HSync(hs), .i_VSync(vs2),
        .o_HSync(o2_hs), .o_VSync(o2_vs), .o_Col_Count(o2_col), .o_Row_Count(o2_row),
        .o_Active(o2_act), .o_Frame_Start(o2_fs), .o_Line_Start(o2_ls),
        .o_Locked(o2_lock), .o_Lock_Err(o2_err), .o_Frame_Count(o2_fcnt),
        .o_Err_Count(o2_ecnt), .o_State(o2_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_err) err_seen++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse();
        vs = 1'b1;
        tick();
        vs = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_hs"},    32'(o_hs),    0);
        check({tag, "_vs"},    32'(o_vs),    0);
        check({tag, "_col"},   32'(o_col),   0);
        check({tag, "_row"},   32'(o_row),   0);
        check({tag, "_act"},   32'(o_act),   0);
        check({tag, "_fs"},    32'(o_fs),    0);
        check({tag, "_ls"},    32'(o_ls),    0);
        check({tag, "_lock"},  32'(o_lock),  0);
        check({tag, "_err"},   32'(o_err),   0);
        check({tag, "_fcnt"},  32'(o_fcnt),  0);
        check({tag, "_ecnt"},  32'(o_ecnt),  0);
        check({tag, "_state"}, 32'(o_state), 0);
        check({tag, "_vs2"},   32'(o2_vs),   0);
        check({tag, "_col2"},  32'(o2_col),  0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        err_seen    = 0;
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;

        // Reset state, then free-running count from 0
        ticks(2);
        check_zero("rst");
        rst = 1'b0;
        tick();
        check("run_col1", 32'(o_col), 1);
        hs = 1'b1;
        ticks(4);
        check("run_col5", 32'(o_col), 5);
        check("run_hs", 32'(o_hs), 1);

        // Asynchronous reset mid-line clears everything before the next edge
        #2;
        rst = 1'b1;
        #1;
        check_zero("arst");
        hs = 1'b0;
        #1;
        rst = 1'b0;
        #0;
        check("arst_rel_col", 32'(o_col), 0);
        check("arst_rel_ls", 32'(o_ls), 1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        while (exp_q.size() > 0) begin
            tick();
            exp_v = exp_q.pop_front();
            check("rel_col", 32'(o_col), exp_v);
        end

        // First VSync edge: counters to (0,0), strobe, IDLE -> ACQ
        pulse();
        check("edge_col", 32'(o_col), 0);
        check("edge_row", 32'(o_row), 0);
        check("edge_fs", 32'(o_fs), 1);
        check("edge_vs", 32'(o_vs), 1);
        check("edge_state", 32'(o_state), 1);
        check("edge2_col", 32'(o2_col), 0);
        check("edge2_row", 32'(o2_row), 0);
        check("edge2_fs", 32'(o2_fs), 1);
        check("edge2_vs", 32'(o2_vs), 0);
        ticks(1);
        check("fs_drop", 32'(o_fs), 0);
        ticks(6);
        check("act_c7", 32'(o_act), 1);
        check("ls_c7", 32'(o_ls), 0);
        ticks(1);
        check("act_c8", 32'(o_act), 0);
        ticks(2);
        check("wrap_col", 32'(o_col), 0);
        check("wrap_row", 32'(o_row), 1);
        check("ls_c0", 32'(o_ls), 1);
        check("act_r1", 32'(o_act), 1);
        ticks(30);
        check("r4_row", 32'(o_row), 4);
        check("act_r4", 32'(o_act), 0);
        ticks(19);
        check("fe_col", 32'(o_col), 9);
        check("fe_row", 32'(o_row), 5);

        // Periodic 60-clk frames: lock on the 4th edge
        err_seen = 0;
        pulse();
        check("acq1_lock", 32'(o_lock), 0);
        ticks(59);
        pulse();
        check("acq2_lock", 32'(o_lock), 0);
        ticks(59);
        pulse();
        check("lock_rise", 32'(o_lock), 1);
        check("lock_state", 32'(o_state), 2);
        check("lock_noerr", 32'(err_seen), 0);
        check("lock2", 32'(o2_lock), 1);

        // Short frame: edge at (4,2) drops lock, then relock after 3 good frames
        ticks(24);
        check("short_col", 32'(o_col), 4);
        check("short_row", 32'(o_row), 2);
        pulse();
        check("short_err", 32'(o_err), 1);
        check("short_lock", 32'(o_lock), 0);
        check("short_col0", 32'(o_col), 0);
        check("short_row0", 32'(o_row), 0);
        check("short_err2", 32'(o2_err), 1);
        ticks(1);
        check("short_err_drop", 32'(o_err), 0);
        ticks(58);
        pulse();
        check("relock1", 32'(o_lock), 0);
        ticks(59);
        pulse();
        check("relock2", 32'(o_lock), 0);
        ticks(59);
        pulse();
        check("relock3", 32'(o_lock), 1);

        // Missing VSync: lock lost at FrameEnd, counters wrap, stays unlocked
        err_seen = 0;
        ticks(59);
        check("miss_col", 32'(o_col), 9);
        check("miss_row", 32'(o_row), 5);
        check("miss_lock_pre", 32'(o_lock), 1);
        ticks(1);
        check("miss_err", 32'(o_err), 1);
        check("miss_lock", 32'(o_lock), 0);
        check("miss_col0", 32'(o_col), 0);
        check("miss_row0", 32'(o_row), 0);
        ticks(59);
        ticks(1);
        check("miss_again_col", 32'(o_col), 0);
        check("miss_again_lock", 32'(o_lock), 0);
        check("miss_err_once", 32'(err_seen), 1);
        check("miss_state", 32'(o_state), 1);

        // Statistics: 8 edges and 2 lock losses across the run
`ifdef SYNC_TRACKER_STATS_EN
        check("stat_fcnt", 32'(o_fcnt), 8);
        check("stat_ecnt", 32'(o_ecnt), 2);
        check("stat_fcnt2", 32'(o2_fcnt), 8);
        check("stat_ecnt2", 32'(o2_ecnt), 2);
`else
        check("stat_fcnt", 32'(o_fcnt), 0);
        check("stat_ecnt", 32'(o_ecnt), 0);
        check("stat_fcnt2", 32'(o2_fcnt), 0);
        check("stat_ecnt2", 32'(o2_ecnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
